// File: rtl/irq_pending_latch.sv
// -----------------------------------------------------------------------------
// irq_pending_latch
//   Front end of the interrupt controller. Each raw, asynchronous peripheral
//   IRQ line goes through a synchroniser into a per-line pending latch. The
//   latch is rising-edge or level triggered, selected per line by EDGE_TRIG.
//   It holds the request until the controller's per-line finish pulse clears
//   it. Sticky overrun flags record edges that arrive while a request is
//   already pending and is not being finished in the same cycle.
//
// Parameters
//   N_IRQ        number of IRQ lines (1..32)
//   SYNC_STAGES  synchroniser depth (2..4)
//   EDGE_TRIG    bit i = 1: line i is rising-edge triggered; 0: level triggered
//
// Ports
//   clk_i       in   system clock, rising edge
//   rst_i       in   asynchronous active-high reset
//   irq_i       in   [N_IRQ] raw peripheral requests (asynchronous)
//   fin_i       in   [N_IRQ] per-line service-done pulse from the controller
//   ovr_clr_i   in   [N_IRQ] per-line overrun clear pulse
//   int_req_o   out  [N_IRQ] registered pending vector
//   ovr_o       out  [N_IRQ] sticky overrun flags
//   any_pend_o  out  OR of int_req_o, registered in the same cycle
//
// Interface contract: there is no handshake. fin_i and ovr_clr_i are single-
// cycle pulses sampled on clk_i. Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module irq_pending_latch #(
  parameter int          N_IRQ       = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] EDGE_TRIG   = 32'hFFFF_FFFF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [N_IRQ-1:0] fin_i,
  input  logic [N_IRQ-1:0] ovr_clr_i,
  output logic [N_IRQ-1:0] int_req_o,
  output logic [N_IRQ-1:0] ovr_o,
  output logic             any_pend_o
);

  localparam logic [N_IRQ-1:0] EDGE_MASK = EDGE_TRIG[N_IRQ-1:0];

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] sync_s;     // last synchroniser stage
  logic [N_IRQ-1:0] prev_q;     // sync_s delayed one clock
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] set_req;
  logic [N_IRQ-1:0] ovr_ev;
  logic [N_IRQ-1:0] req_nxt;
  logic [N_IRQ-1:0] ovr_nxt;
  logic [N_IRQ-1:0] req_q;
  logic [N_IRQ-1:0] ovr_q;
  logic             any_q;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain and edge history.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_i;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      prev_q <= sync_s;
    end
  end

  always_comb begin
    rise    = sync_s & ~prev_q;
    set_req = (EDGE_MASK & rise) | (~EDGE_MASK & sync_s);
    // A new request wins over a same-cycle finish, so no event is dropped.
    req_nxt = set_req | (req_q & ~fin_i);
    // An edge counts as lost only if the line is still pending after this
    // cycle's finish. Level lines never overrun.
    ovr_ev  = EDGE_MASK & rise & req_q & ~fin_i;
    // The clear pulse wins over a same-cycle overrun event.
    ovr_nxt = ~ovr_clr_i & (ovr_q | ovr_ev);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q <= '0;
      ovr_q <= '0;
      any_q <= 1'b0;
    end else begin
      req_q <= req_nxt;
      ovr_q <= ovr_nxt;
      // Built from the next-state vector so it changes in the same cycle as req_q.
      any_q <= |req_nxt;
    end
  end

  assign int_req_o  = req_q;
  assign ovr_o      = ovr_q;
  assign any_pend_o = any_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
module tb_irq_pending_latch;

  logic        clk;
  logic        clk_en;
  logic        rst_i;
  logic [31:0] irq_i;
  logic [31:0] fin_i;
  logic [31:0] ovr_clr_i;
  logic [31:0] int_req_o;
  logic [31:0] ovr_o;
  logic        any_pend_o;

  int n_cmp;
  int n_err;

  // Line 0 is level triggered; all others are edge triggered.
  irq_pending_latch #(
    .N_IRQ       (32),
    .SYNC_STAGES (2),
    .EDGE_TRIG   (32'hFFFF_FFFE)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .irq_i      (irq_i),
    .fin_i      (fin_i),
    .ovr_clr_i  (ovr_clr_i),
    .int_req_o  (int_req_o),
    .ovr_o      (ovr_o),
    .any_pend_o (any_pend_o)
  );

  // Clock / reset block: the clock can be held still to show that reset
  // acts without any edge.
  initial clk = 1'b0;
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock, then settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_fin(input logic [31:0] v);
    fin_i = v;
    step();
    fin_i = '0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    clk_en    = 1'b0;
    rst_i     = 1'b0;
    irq_i     = 32'hFFFF_FFFF;
    fin_i     = '0;
    ovr_clr_i = '0;

    // 1 Reset with no clock running, then with the clock running.
    #2 rst_i = 1'b1;
    #3;
    check_val("rst_req_noclk", int_req_o, 32'h0);
    check_val("rst_ovr_noclk", ovr_o, 32'h0);
    check_val("rst_any_noclk", {31'b0, any_pend_o}, 32'h0);
    #20;
    check_val("rst_req_hold", int_req_o, 32'h0);
    clk_en = 1'b1;
    steps(4);
    check_val("rst_req_clk", int_req_o, 32'h0);
    check_val("rst_any_clk", {31'b0, any_pend_o}, 32'h0);
    irq_i = '0;
    steps(4);
    rst_i = 1'b0;
    steps(2);
    check_val("idle_req", int_req_o, 32'h0);

    // 2 Latency on edge line 3: pending after the third edge.
    irq_i[3] = 1'b1;
    step();
    check_val("lat_e1", int_req_o, 32'h0);
    step();
    check_val("lat_e2", int_req_o, 32'h0);
    step();
    check_val("lat_e3", int_req_o, 32'h8);
    check_val("lat_any", {31'b0, any_pend_o}, 32'h1);

    // 3 Finish clears it on the next edge; a held edge line stays quiet.
    pulse_fin(32'h8);
    check_val("fin_clr", int_req_o, 32'h0);
    check_val("fin_any", {31'b0, any_pend_o}, 32'h0);
    steps(18);
    check_val("held_no_rereq", int_req_o, 32'h0);
    pulse_fin(32'h10);
    check_val("fin_idle_line", int_req_o, 32'h0);
    irq_i[3] = 1'b0;
    steps(4);

    // 4 Collision on line 5: new sync edge in the same cycle as fin_i[5].
    irq_i[5] = 1'b1;
    steps(3);
    check_val("col_pend", int_req_o, 32'h20);
    irq_i[5] = 1'b0;
    steps(4);
    irq_i[5] = 1'b1;
    steps(2);          // rising edge now visible at the last sync stage
    fin_i = 32'h20;
    step();
    fin_i = '0;
    check_val("col_req", int_req_o, 32'h20);
    check_val("col_ovr", ovr_o, 32'h0);
    pulse_fin(32'h20);
    check_val("col_done", int_req_o, 32'h0);
    irq_i[5] = 1'b0;
    steps(4);

    // 5 Overrun on line 7.
    irq_i[7] = 1'b1;
    steps(3);
    check_val("ovr_pend", int_req_o, 32'h80);
    irq_i[7] = 1'b0;
    steps(4);
    irq_i[7] = 1'b1;
    steps(3);
    check_val("ovr_set", ovr_o, 32'h80);
    check_val("ovr_req", int_req_o, 32'h80);
    steps(5);
    check_val("ovr_sticky", ovr_o, 32'h80);
    ovr_clr_i = 32'h80;
    step();
    ovr_clr_i = '0;
    check_val("ovr_clr", ovr_o, 32'h0);
    irq_i[7] = 1'b0;
    steps(4);
    irq_i[7] = 1'b1;
    steps(2);          // overrun event will be evaluated on the next edge
    ovr_clr_i = 32'h80;
    step();
    ovr_clr_i = '0;
    check_val("ovr_clr_wins", ovr_o, 32'h0);
    step();
    check_val("ovr_clr_after", ovr_o, 32'h0);
    pulse_fin(32'h80);
    check_val("ovr_line_done", int_req_o, 32'h0);
    irq_i[7] = 1'b0;
    steps(4);

    // 6 Level line 0.
    irq_i[0] = 1'b1;
    steps(3);
    check_val("lvl_pend", int_req_o, 32'h1);
    pulse_fin(32'h1);
    check_val("lvl_fin_held", int_req_o, 32'h1);
    check_val("lvl_ovr", ovr_o, 32'h0);
    irq_i[0] = 1'b0;
    steps(3);
    check_val("lvl_after_drop", int_req_o, 32'h1);
    pulse_fin(32'h1);
    check_val("lvl_cleared", int_req_o, 32'h0);
    check_val("lvl_any", {31'b0, any_pend_o}, 32'h0);
    steps(2);

    // Reset asserted mid-operation discards pending state at once.
    irq_i[9] = 1'b1;
    steps(3);
    check_val("mid_pend", int_req_o, 32'h200);
    #2 rst_i = 1'b1;
    #1;
    check_val("mid_rst_req", int_req_o, 32'h0);
    check_val("mid_rst_any", {31'b0, any_pend_o}, 32'h0);
    irq_i = '0;
    steps(3);
    rst_i = 1'b0;
    steps(3);
    check_val("post_rst_req", int_req_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
